// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage.
// Registers the EX->MEM bus under stall control, extracts load data from the
// synchronous data SRAM with a hold buffer that survives MEM stalls, and drives
// the MEM->WB and MEM->ID forwarding buses.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 80,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id_bus
);

    // ------------------------------------------------------------------
    // Field positions of the EX->MEM bus (identical for the registered copy)
    // ------------------------------------------------------------------
    localparam int PC_LSB     = 48;
    localparam int EN_BIT     = 47;
    localparam int WEN_LSB    = 43;
    localparam int SEL_BIT    = 42;
    localparam int WE_BIT     = 41;
    localparam int WADDR_LSB  = 36;
    localparam int RES_LSB    = 4;
    localparam int RD_LSB     = 0;

    // Load flavours decoded from data_ram_read, lowest bit has priority.
    typedef enum logic [2:0] {
        LD_WORD = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4
    } load_kind_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_q, ex_to_mem_bus_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [31:0]             hold_data_q, hold_data_d;

    // ------------------------------------------------------------------
    // Stall decode: a stall bit of 1 means Stop.
    // ------------------------------------------------------------------
    logic mem_stop;
    logic wb_stop;
    logic insert_bubble;
    logic capture;
    logic reg_write;
    logic stall_unused;

    assign mem_stop      = stall[3];
    assign wb_stop       = stall[4];
    assign insert_bubble = mem_stop & ~wb_stop;
    assign capture       = ~mem_stop;
    assign reg_write     = insert_bubble | capture;

    // Only the MEM and WB stall bits matter to this stage.
    assign stall_unused  = ^{stall[STALL_WD-1:5], stall[2:0]};

    // ------------------------------------------------------------------
    // Field decode of the registered instruction
    // ------------------------------------------------------------------
    logic [31:0] mem_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [3:0]  data_ram_read;
    logic [1:0]  lane;
    logic        is_load;

    assign mem_pc        = ex_to_mem_bus_q[PC_LSB +: 32];
    assign data_ram_en   = ex_to_mem_bus_q[EN_BIT];
    assign data_ram_wen  = ex_to_mem_bus_q[WEN_LSB +: 4];
    assign sel_rf_res    = ex_to_mem_bus_q[SEL_BIT];
    assign rf_we         = ex_to_mem_bus_q[WE_BIT];
    assign rf_waddr      = ex_to_mem_bus_q[WADDR_LSB +: 5];
    assign ex_result     = ex_to_mem_bus_q[RES_LSB +: 32];
    assign data_ram_read = ex_to_mem_bus_q[RD_LSB +: 4];
    assign lane          = ex_result[1:0];
    assign is_load       = data_ram_en & sel_rf_res & (data_ram_wen == 4'b0000);

    // Next value of the pipeline register: bubble beats capture beats hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ex_to_mem_bus_d = ex_to_mem_bus_q;
        if (insert_bubble) begin
            ex_to_mem_bus_d = '0;
        end else if (capture) begin
            ex_to_mem_bus_d = ex_to_mem_bus;
        end
    end

    // Hold buffer: snapshot the SRAM word on the first stalled cycle of a load.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (reg_write) begin
            // A new occupant (instruction or bubble) always reads fresh data.
            hold_valid_d = 1'b0;
        end else if (is_load && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_data_d  = data_sram_rdata;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!resetn) begin
            ex_to_mem_bus_q <= '0;
            hold_valid_q    <= 1'b0;
            hold_data_q     <= 32'h0;
        end else begin
            ex_to_mem_bus_q <= ex_to_mem_bus_d;
            hold_valid_q    <= hold_valid_d;
            hold_data_q     <= hold_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Load data path
    // ------------------------------------------------------------------
    logic [31:0] rdata_eff;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    load_kind_e  load_kind;
    logic [31:0] load_result;
    logic [31:0] mem_result;

    // Held copy wins once the load has been stalled past its SRAM cycle.
    assign rdata_eff = hold_valid_q ? hold_data_q : data_sram_rdata;

    // Little-endian byte and halfword lane selection.
    always_comb begin
        load_byte = rdata_eff[7:0];
        case (lane)
            2'd0: load_byte = rdata_eff[7:0];
            2'd1: load_byte = rdata_eff[15:8];
            2'd2: load_byte = rdata_eff[23:16];
            2'd3: load_byte = rdata_eff[31:24];
            default: load_byte = rdata_eff[7:0];
        endcase
        load_half = lane[1] ? rdata_eff[31:16] : rdata_eff[15:0];
    end

    // Load type decode with priority lb > lbu > lh > lhu; none set means lw.
    always_comb begin
        load_kind = LD_WORD;
        if (data_ram_read[0]) begin
            load_kind = LD_B;
        end else if (data_ram_read[1]) begin
            load_kind = LD_BU;
        end else if (data_ram_read[2]) begin
            load_kind = LD_H;
        end else if (data_ram_read[3]) begin
            load_kind = LD_HU;
        end
    end

    // Sign or zero extension of the selected lane.
    always_comb begin
        load_result = rdata_eff;
        case (load_kind)
            LD_B:    load_result = {{24{load_byte[7]}}, load_byte};
            LD_BU:   load_result = {24'h0, load_byte};
            LD_H:    load_result = {{16{load_half[15]}}, load_half};
            LD_HU:   load_result = {16'h0, load_half};
            default: load_result = rdata_eff;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_result    = sel_rf_res ? load_result : ex_result;
    assign mem_to_wb_bus = {mem_pc, rf_we, rf_waddr, mem_result};
    assign mem_to_id_bus = {rf_we, rf_waddr, mem_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus a randomized run against a
// behavioural model of the MEM stage.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic [5:0]  stall;
    logic [79:0] ex_bus;
    logic [31:0] rdata;
    logic [69:0] wb_bus;
    logic [37:0] id_bus;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb_bus),
        .mem_to_id_bus   (id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] S_RUN    = 6'b000000;
    localparam logic [5:0] S_HOLD   = 6'b011000;
    localparam logic [5:0] S_BUBBLE = 6'b001111;

    // Build an EX->MEM bus from its fields.
    function automatic logic [79:0] mk(input logic [31:0] pc, input logic en,
                                       input logic [3:0] wen, input logic sel,
                                       input logic we, input logic [4:0] wa,
                                       input logic [31:0] res, input logic [3:0] rd);
        return {pc, en, wen, sel, we, wa, res, rd};
    endfunction

    function automatic logic [79:0] mk_load(input logic [31:0] pc, input logic [4:0] wa,
                                            input logic [31:0] addr, input logic [3:0] rd);
        return mk(pc, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr, rd);
    endfunction

    // ---------------- behavioural reference ----------------
    logic [79:0] m_instr;
    bit          m_fresh;
    logic [31:0] m_saved;

    function automatic bit m_is_load(input logic [79:0] b);
        return b[47] && b[42] && (b[46:43] == 4'h0);
    endfunction

    // Expected MEM->WB bus for instruction b that sees memory word w.
    function automatic logic [69:0] ref_wb(input logic [79:0] b, input logic [31:0] w);
        logic [31:0] addr;
        logic [3:0]  rd;
        logic [7:0]  bt;
        logic [15:0] hf;
        logic [31:0] res;
        addr = b[35:4];
        rd   = b[3:0];
        bt   = 8'((w >> (8 * addr[1:0])) & 32'hFF);
        hf   = 16'((w >> (16 * addr[1])) & 32'hFFFF);
        if (!b[42])     res = addr;
        else if (rd[0]) res = 32'($signed(bt));
        else if (rd[1]) res = 32'(bt);
        else if (rd[2]) res = 32'($signed(hf));
        else if (rd[3]) res = 32'(hf);
        else            res = w;
        return {b[79:48], b[41], b[40:36], res};
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic m_edge(input logic rn, input logic [5:0] st,
                          input logic [79:0] b, input logic [31:0] w);
        if (!rn || (st[3] && !st[4])) begin
            m_instr = '0;
            m_fresh = 1'b1;
        end else if (!st[3]) begin
            m_instr = b;
            m_fresh = 1'b1;
        end else if (m_fresh && m_is_load(m_instr)) begin
            m_saved = w;
            m_fresh = 1'b0;
        end
    endtask

    // Clock edge then settle inputs just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [79:0] b;
        b = mk(32'hA5A5_0004, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 4'h0);
        resetn = 1'b0; stall = S_RUN; ex_bus = b; rdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            total++;
            if (wb_bus !== 70'h0 || id_bus !== 38'h0) begin
                bad++;
                $display("FAIL reset_hold[%0d] wb=%h id=%h need 0", i, wb_bus, id_bus);
            end
        end
        resetn = 1'b1;
        cyc();
        @(negedge clk);
        total++;
        if (wb_bus !== {32'hA5A5_0004, 1'b1, 5'd9, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL reset_release wb=%h need %h", wb_bus,
                     {32'hA5A5_0004, 1'b1, 5'd9, 32'hCAFE_F00D});
        end
    endtask

    task automatic test_alu();
        logic [69:0] exp_wb;
        ex_bus = mk(32'hBFC0_0010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 4'h0);
        stall = S_RUN; rdata = 32'hFFFF_FFFF;
        exp_wb = {32'hBFC0_0010, 1'b1, 5'd5, 32'h1234_5678};
        cyc();
        @(negedge clk);
        total++;
        if (wb_bus !== exp_wb) begin
            bad++;
            $display("FAIL alu_wb got=%h need=%h", wb_bus, exp_wb);
        end
        total++;
        if (id_bus !== exp_wb[37:0]) begin
            bad++;
            $display("FAIL alu_id got=%h need=%h", id_bus, exp_wb[37:0]);
        end
    endtask

    task automatic test_loads();
        logic [3:0]  rd_t  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        logic [1:0]  ad_t  [5] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
        logic [31:0] exp_t [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                                   32'h0000_7F01, 32'h80FF_7F01};
        stall = S_RUN;
        for (int i = 0; i < 5; i++) begin
            ex_bus = mk_load(32'h8000_0100 + 32'(4 * i), 5'd7,
                             {30'h0400_0000, ad_t[i]}, rd_t[i]);
            rdata = 32'h0;
            cyc();
            rdata = 32'h80FF_7F01;
            @(negedge clk);
            total++;
            if (wb_bus[31:0] !== exp_t[i]) begin
                bad++;
                $display("FAIL load[%0d] rd=%b lane=%0d got=%h need=%h",
                         i, rd_t[i], ad_t[i], wb_bus[31:0], exp_t[i]);
            end
        end
    endtask

    task automatic test_stall_hold();
        stall = S_RUN;
        ex_bus = mk_load(32'h8000_0200, 5'd3, 32'h1000_0000, 4'h0);
        cyc();
        rdata = 32'hDEAD_BEEF;
        stall = S_HOLD;
        ex_bus = mk(32'h8000_0204, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h5555_5555, 4'h0);
        @(negedge clk);
        total++;
        if (wb_bus[31:0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL hold_first got=%h need=deadbeef", wb_bus[31:0]);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            rdata = 32'h0;
            @(negedge clk);
            total++;
            if (wb_bus !== {32'h8000_0200, 1'b1, 5'd3, 32'hDEAD_BEEF}) begin
                bad++;
                $display("FAIL hold_stall[%0d] got=%h need pc=80000200 data=deadbeef",
                         i, wb_bus);
            end
        end
        stall = S_RUN;
        #1;
        total++;
        if (wb_bus[31:0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL hold_release got=%h need=deadbeef", wb_bus[31:0]);
        end
        cyc();
        @(negedge clk);
        total++;
        if (wb_bus !== {32'h8000_0204, 1'b1, 5'd4, 32'h5555_5555}) begin
            bad++;
            $display("FAIL hold_next got=%h", wb_bus);
        end
    endtask

    task automatic test_bubble();
        // Leave a held load in MEM, then bubble it out.
        stall = S_RUN;
        ex_bus = mk_load(32'h8000_0300, 5'd8, 32'h2000_0000, 4'h0);
        cyc();
        rdata = 32'hAAAA_5555;
        stall = S_HOLD;
        cyc();
        rdata = 32'h0;
        stall = S_BUBBLE;
        cyc();
        @(negedge clk);
        total++;
        if (wb_bus !== 70'h0 || id_bus !== 38'h0) begin
            bad++;
            $display("FAIL bubble wb=%h id=%h need 0", wb_bus, id_bus);
        end
        // A fresh load after the bubble must not see the old held word.
        stall = S_RUN;
        ex_bus = mk_load(32'h8000_0304, 5'd9, 32'h2000_0004, 4'h0);
        cyc();
        rdata = 32'h1357_2468;
        @(negedge clk);
        total++;
        if (wb_bus[31:0] !== 32'h1357_2468) begin
            bad++;
            $display("FAIL bubble_fresh got=%h need=13572468", wb_bus[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [2] = '{32'h1111_1111, 32'h2222_2222};
        stall = S_RUN;
        for (int i = 0; i < 2; i++) begin
            ex_bus = mk_load(32'h8000_0400 + 32'(4 * i), 5'(10 + i),
                             32'h3000_0000 + 32'(4 * i), 4'h0);
            cyc();
            rdata = words[i];
            @(negedge clk);
            total++;
            if (wb_bus !== {32'h8000_0400 + 32'(4 * i), 1'b1, 5'(10 + i), words[i]}) begin
                bad++;
                $display("FAIL b2b[%0d] got=%h need data=%h", i, wb_bus, words[i]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        stall = S_RUN;
        ex_bus = mk_load(32'h8000_0500, 5'd12, 32'h4000_0000, 4'h0);
        cyc();
        rdata = 32'h0BAD_0BAD;
        stall = S_HOLD;
        cyc();
        resetn = 1'b0;
        cyc();
        @(negedge clk);
        total++;
        if (wb_bus !== 70'h0 || id_bus !== 38'h0) begin
            bad++;
            $display("FAIL reset_mid_stall wb=%h id=%h need 0", wb_bus, id_bus);
        end
        resetn = 1'b1;
        stall = S_RUN;
        ex_bus = mk_load(32'h8000_0504, 5'd13, 32'h4000_0004, 4'h0);
        cyc();
        rdata = 32'h7654_3210;
        @(negedge clk);
        total++;
        if (wb_bus[31:0] !== 32'h7654_3210) begin
            bad++;
            $display("FAIL reset_fresh got=%h need=76543210", wb_bus[31:0]);
        end
    endtask

    task automatic test_random();
        logic [69:0] exp_wb;
        logic [3:0]  rd_pick [6] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
        resetn = 1'b0;
        stall  = S_RUN;
        m_instr = '0; m_fresh = 1'b1; m_saved = '0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            m_edge(resetn, stall, ex_bus, rdata);
            #1;
            resetn = ($urandom_range(0, 19) != 0);
            stall  = 6'($urandom);
            rdata  = $urandom;
            if ($urandom_range(0, 9) < 6)
                ex_bus = mk_load($urandom, 5'($urandom), $urandom,
                                 rd_pick[$urandom_range(0, 5)]);
            else
                ex_bus = {$urandom, $urandom, 16'($urandom)};
            @(negedge clk);
            exp_wb = ref_wb(m_instr, m_fresh ? rdata : m_saved);
            total++;
            if (wb_bus !== exp_wb || id_bus !== exp_wb[37:0]) begin
                bad++;
                $display("FAIL random[%0d] wb=%h id=%h need=%h", n, wb_bus, id_bus, exp_wb);
            end
        end
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        stall  = S_RUN;
        ex_bus = '0;
        rdata  = '0;
        test_reset();
        test_alu();
        test_loads();
        test_stall_hold();
        test_bubble();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
